// File: rtl/arb_buf_pkg.sv
// Shared constants and width helpers for the arbiter request buffer.
//   DefNumReq / DefDataWidth / DefDepth : default instance sizing
//   src_width(n)  : bits needed for a client index (minimum 1)
//   cnt_width(d)  : bits needed for a 0..d occupancy count
package arb_buf_pkg;

  localparam int DefNumReq    = 3;
  localparam int DefDataWidth = 8;
  localparam int DefDepth     = 4;

  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Single-clock per-client FIFO. Pointers wrap modulo Depth (power of two);
// an explicit count register distinguishes full from empty.
//   clk, rstN : clock and asynchronous active-low reset (control only)
//   push, din : write strobe and data, ignored while full
//   pop       : read strobe, ignored while empty
//   dout      : current head entry
//   empty     : no entries held
//   full      : Depth entries held
module arb_req_fifo
  import arb_buf_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int Depth     = DefDepth
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] din,
  output logic [DataWidth-1:0] dout,
  output logic                 empty,
  output logic                 full
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = cnt_width(Depth);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  // A full FIFO refuses the push even when popped in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/arb_req_buffer.sv
// Front-end of a round-robin arbiter: one FIFO per client, request vector
// from non-empty FIFOs, pop of the granted FIFO into a registered output.
//   clk, rstN          : clock and asynchronous active-low reset
//   in_valid/in_data   : per-client push strobe and payload
//   in_ready           : per-client space available (0 during reset)
//   req_out            : requests to the arbiter
//   grant_in           : arbiter grant, combinational from req_out
//   out_valid/out_data : held output entry
//   out_src            : client index of the held entry
//   out_ready          : downstream accept
module arb_req_buffer
  import arb_buf_pkg::*;
#(
  parameter int NumReq    = DefNumReq,
  parameter int DataWidth = DefDataWidth,
  parameter int Depth     = DefDepth
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic [NumReq-1:0]                  in_valid,
  input  logic [NumReq-1:0][DataWidth-1:0]   in_data,
  output logic [NumReq-1:0]                  in_ready,
  output logic [NumReq-1:0]                  req_out,
  input  logic [NumReq-1:0]                  grant_in,
  output logic                               out_valid,
  output logic [DataWidth-1:0]               out_data,
  output logic [src_width(NumReq)-1:0]       out_src,
  input  logic                               out_ready
);

  localparam int SrcW = src_width(NumReq);

  logic [DataWidth-1:0] head [NumReq];
  logic [NumReq-1:0]    empty;
  logic [NumReq-1:0]    full;
  logic [NumReq-1:0]    push;
  logic [NumReq-1:0]    pop;
  logic                 advance;
  logic                 hit;
  logic [SrcW-1:0]      sel;
  logic [DataWidth-1:0] sel_data;

  assign in_ready = rstN ? ~full : '0;
  assign push     = in_valid & in_ready;
  assign advance  = !out_valid || out_ready;
  // Dropping all requests while stalled keeps the arbiter's mask frozen.
  assign req_out  = {NumReq{advance}} & ~empty;

  for (genvar g = 0; g < NumReq; g++) begin : g_fifo
    arb_req_fifo #(
      .DataWidth(DataWidth),
      .Depth    (Depth)
    ) u_fifo (
      .clk  (clk),
      .rstN (rstN),
      .push (push[g]),
      .pop  (pop[g]),
      .din  (in_data[g]),
      .dout (head[g]),
      .empty(empty[g]),
      .full (full[g])
    );
  end

  // Descending scan so the lowest requesting granted index wins when the
  // grant is not one-hot; grant bits on idle lines are masked by req_out.
  always_comb begin
    hit      = 1'b0;
    sel      = '0;
    sel_data = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (grant_in[i] && req_out[i]) begin
        hit      = 1'b1;
        sel      = SrcW'(i);
        sel_data = head[i];
      end
    end
    pop = hit ? (NumReq'(1) << sel) : '0;
  end

  // Output register stage
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (advance) begin
      out_valid <= hit;
      if (hit) begin
        out_data <= sel_data;
        out_src  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_arb_req_buffer.sv
module tb_arb_req_buffer;

  localparam int N = 3;
  localparam int W = 8;
  localparam int D = 4;

  logic                clk = 1'b0;
  logic                rstN = 1'b0;
  logic [N-1:0]        in_valid = '0;
  logic [N-1:0][W-1:0] in_data = '0;
  logic [N-1:0]        in_ready;
  logic [N-1:0]        req_out;
  logic [N-1:0]        grant_in;
  logic                out_valid;
  logic [W-1:0]        out_data;
  logic [1:0]          out_src;
  logic                out_ready = 1'b0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  arb_req_buffer #(.NumReq(N), .DataWidth(W), .Depth(D)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .req_out  (req_out),
    .grant_in (grant_in),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready)
  );

  // Round-robin arbiter stand-in, with an override for forced grants.
  logic         force_en = 1'b0;
  logic [N-1:0] force_val = '0;
  logic [N-1:0] grant_rr;
  int           rr_ptr;

  always_comb begin
    int idx;
    grant_rr = '0;
    for (int k = 0; k < N; k++) begin
      idx = (rr_ptr + k) % N;
      if (req_out[idx] && grant_rr == '0) grant_rr[idx] = 1'b1;
    end
    grant_in = force_en ? force_val : grant_rr;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rr_ptr <= 0;
    else for (int k = 0; k < N; k++) if (grant_rr[k] && !force_en) rr_ptr <= (k + 1) % N;
  end

  // Behavioural reference: one queue per client plus the output holding slot.
  logic [W-1:0] q [N][$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [1:0]   m_src = '0;

  function automatic logic [N-1:0] m_req();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (q[i].size() != 0) && (!m_valid || out_ready);
    return r;
  endfunction

  function automatic logic [N-1:0] m_rdy();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = rstN && (q[i].size() != D);
    return r;
  endfunction

  always @(posedge clk or negedge rstN) begin
    logic [N-1:0] r;
    logic [N-1:0] fl;
    bit           got;
    int           s;
    if (!rstN) begin
      for (int i = 0; i < N; i++) q[i].delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = '0;
    end else begin
      r = m_req();
      for (int i = 0; i < N; i++) fl[i] = (q[i].size() == D);
      got = 1'b0;
      s   = 0;
      for (int i = 0; i < N; i++) if (!got && grant_in[i] && r[i]) begin got = 1'b1; s = i; end
      if (!m_valid || out_ready) begin
        m_valid = got;
        if (got) begin
          m_data = q[s].pop_front();
          m_src  = 2'(s);
        end
      end
      for (int i = 0; i < N; i++) if (in_valid[i] && !fl[i]) q[i].push_back(in_data[i]);
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic rdy);
    @(negedge clk);
    in_valid = v;
    for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
    out_ready = rdy;
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vecs++;
    if ({in_ready, req_out} !== 6'b0) begin
      errs++; $display("FAIL reset_ctrl: in_ready=%b req_out=%b required 000/000", in_ready, req_out);
    end
    vecs++;
    if ({out_valid, out_data, out_src} !== 11'b0) begin
      errs++; $display("FAIL reset_out: valid=%b data=%h src=%0d required 0/00/0", out_valid, out_data, out_src);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 3'b111) begin
      errs++; $display("FAIL reset_release: in_ready=%b required 111", in_ready);
    end
  endtask

  task automatic test_single;
    drive(3'b010, 1'b1);
    in_data[1] = 8'hA5;
    drive(3'b000, 1'b1);
    vecs++;
    if (req_out !== 3'b010) begin
      errs++; $display("FAIL single_req: req_out=%b required 010", req_out);
    end
    drive(3'b000, 1'b1);
    vecs++;
    if ({out_valid, out_data, out_src} !== {1'b1, 8'hA5, 2'd1}) begin
      errs++; $display("FAIL single_out: valid=%b data=%h src=%0d required 1/a5/1", out_valid, out_data, out_src);
    end
    drive(3'b000, 1'b1);
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL single_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_fill;
    int nout;
    for (int c = 0; c < 7; c++) begin
      drive(3'b001, 1'b0);
      vecs++;
      if ({req_out, in_ready, out_valid, out_data, out_src} !== {m_req(), m_rdy(), m_valid, m_data, m_src}) begin
        errs++; $display("FAIL fill_cyc%0d: req=%b rdy=%b v=%b d=%h s=%0d required req=%b rdy=%b v=%b d=%h s=%0d",
                         c, req_out, in_ready, out_valid, out_data, out_src, m_req(), m_rdy(), m_valid, m_data, m_src);
      end
    end
    vecs++;
    if (in_ready[0] !== 1'b0) begin
      errs++; $display("FAIL fill_full: in_ready[0]=%b required 0", in_ready[0]);
    end
    nout = 0;
    for (int c = 0; c < 7; c++) begin
      drive(3'b000, 1'b1);
      if (out_valid === 1'b1) nout++;
      vecs++;
      if ({req_out, in_ready, out_valid, out_data, out_src} !== {m_req(), m_rdy(), m_valid, m_data, m_src}) begin
        errs++; $display("FAIL fill_drain%0d: v=%b d=%h s=%0d required v=%b d=%h s=%0d",
                         c, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
    end
    vecs++;
    if (nout !== 5) begin
      errs++; $display("FAIL fill_count: delivered=%0d required 5", nout);
    end
  endtask

  task automatic test_rr;
    logic [1:0] prev;
    drive(3'b111, 1'b0);
    drive(3'b111, 1'b0);
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      drive(3'b000, 1'b1);
      vecs++;
      if ({out_valid, out_data, out_src} !== {1'b1, m_data, m_src}) begin
        errs++; $display("FAIL rr_out%0d: v=%b d=%h s=%0d required v=1 d=%h s=%0d",
                         c, out_valid, out_data, out_src, m_data, m_src);
      end
      if (c > 0) begin
        vecs++;
        if (out_src !== 2'((prev + 1) % N)) begin
          errs++; $display("FAIL rr_order%0d: src=%0d required %0d", c, out_src, (prev + 1) % N);
        end
      end
      prev = out_src;
    end
    drive(3'b000, 1'b1);
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL rr_end: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] held;
    drive(3'b111, 1'b0);
    drive(3'b111, 1'b0);
    drive(3'b000, 1'b0);
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      drive(3'b000, 1'b0);
      vecs++;
      if ({req_out, out_valid, out_data} !== {3'b000, 1'b1, held}) begin
        errs++; $display("FAIL stall_cyc%0d: req=%b v=%b d=%h required req=000 v=1 d=%h", c, req_out, out_valid, out_data, held);
      end
    end
    for (int c = 0; c < 8; c++) begin
      drive(3'b000, 1'b1);
      vecs++;
      if ({req_out, in_ready, out_valid, out_data, out_src} !== {m_req(), m_rdy(), m_valid, m_data, m_src}) begin
        errs++; $display("FAIL stall_release%0d: v=%b d=%h s=%0d required v=%b d=%h s=%0d",
                         c, out_valid, out_data, out_src, m_valid, m_data, m_src);
      end
    end
  endtask

  task automatic test_grant_force;
    drive(3'b100, 1'b1);
    force_en  = 1'b1;
    force_val = 3'b110;
    drive(3'b000, 1'b1);
    drive(3'b000, 1'b1);
    vecs++;
    if ({out_valid, out_src, req_out} !== {1'b1, 2'd2, 3'b000}) begin
      errs++; $display("FAIL force_c2: v=%b s=%0d req=%b required 1/2/000", out_valid, out_src, req_out);
    end
    drive(3'b110, 1'b1);
    for (int c = 0; c < 4; c++) begin
      drive(3'b000, 1'b1);
      vecs++;
      if ({req_out, in_ready, out_valid, out_data, out_src} !== {m_req(), m_rdy(), m_valid, m_data, m_src}) begin
        errs++; $display("FAIL force_multi%0d: req=%b v=%b d=%h s=%0d required req=%b v=%b d=%h s=%0d",
                         c, req_out, out_valid, out_data, out_src, m_req(), m_valid, m_data, m_src);
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_random;
    for (int c = 0; c < 300; c++) begin
      drive(N'($urandom), $urandom_range(0, 3) != 0);
      vecs++;
      if ({req_out, in_ready, out_valid, out_data, out_src} !== {m_req(), m_rdy(), m_valid, m_data, m_src}) begin
        errs++; $display("FAIL random%0d: req=%b rdy=%b v=%b d=%h s=%0d required req=%b rdy=%b v=%b d=%h s=%0d",
                         c, req_out, in_ready, out_valid, out_data, out_src, m_req(), m_rdy(), m_valid, m_data, m_src);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 8; c++) drive(3'b000, 1'b1);
    drive(3'b001, 1'b0);
    drive(3'b001, 1'b0);
    drive(3'b001, 1'b0);
    drive(3'b001, 1'b0);
    in_valid = '0;
    #2;
    rstN = 1'b0;
    #1;
    vecs++;
    if ({out_valid, in_ready, req_out, out_data} !== 15'b0) begin
      errs++; $display("FAIL midreset: v=%b rdy=%b req=%b d=%h required all 0", out_valid, in_ready, req_out, out_data);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 3'b111) begin
      errs++; $display("FAIL midreset_release: in_ready=%b required 111", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      drive(3'b000, 1'b1);
      vecs++;
      if ({req_out, out_valid} !== 4'b0) begin
        errs++; $display("FAIL midreset_idle%0d: req=%b v=%b required 000/0", c, req_out, out_valid);
      end
    end
    drive(3'b100, 1'b1);
    drive(3'b000, 1'b1);
    vecs++;
    if (req_out !== 3'b100) begin
      errs++; $display("FAIL midreset_push: req_out=%b required 100", req_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_rr();
    test_stall();
    test_grant_force();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
